// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and default widths for pipeline stages
package pipe_pkg;

  localparam int DATA_WIDTH = 36;
  localparam int CTRL_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with a multi-bit increment
module sat_counter #(
  parameter int WIDTH     = 16,
  parameter int INC_WIDTH = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [INC_WIDTH-1:0] i_inc,
  output logic [WIDTH-1:0]     o_count
);

  // One extra bit catches the carry so the count pins at all-ones instead of wrapping.
  logic [WIDTH:0] sum;

  assign sum = {1'b0, o_count} + {{(WIDTH + 1 - INC_WIDTH){1'b0}}, i_inc};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_count <= '0;
    end else if (sum[WIDTH]) begin
      o_count <= '1;
    end else begin
      o_count <= sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline register with skid, hold, flush and perf counters
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = pipe_pkg::DATA_WIDTH,
  parameter int CTRL_WIDTH = pipe_pkg::CTRL_WIDTH,
  parameter int SKID_EN    = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [CTRL_WIDTH-1:0] i_ctrl,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_stall,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [CTRL_WIDTH-1:0] o_ctrl,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CNT_WIDTH-1:0]  o_stall_cnt,
  output logic [CNT_WIDTH-1:0]  o_flush_cnt
);

  state_e                state_q, state_d;
  logic [CTRL_WIDTH-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_WIDTH-1:0] main_data_q, skid_data_q;
  logic                  in_xfer, out_acc, out_xfer;
  logic                  load_main, load_skid, skid_to_main;
  logic                  stall_inc;
  logic [1:0]            flush_inc;

  assign o_valid  = (state_q != ST_EMPTY);
  assign o_ctrl   = main_ctrl_q;
  assign o_data   = main_data_q;
  assign out_acc  = i_ready & ~i_stall;
  assign out_xfer = o_valid & out_acc;
  assign in_xfer  = i_valid & o_ready;

  // With the skid buffer, ready is a flop so upstream never sees downstream's ready/stall path.
  generate
    if (SKID_EN != 0) begin : g_skid
      logic ready_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= (state_d != ST_SKID);
        end
      end
      assign o_ready = ready_q;
    end else begin : g_noskid
      assign o_ready = ~o_valid | out_acc;
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d   = ST_FULL;
            load_main = 1'b1;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            load_main = 1'b1;
          end else if (in_xfer && (SKID_EN != 0)) begin
            state_d   = ST_SKID;
            load_skid = 1'b1;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_xfer) begin
            state_d      = ST_FULL;
            skid_to_main = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (i_flush) begin
        main_ctrl_q <= '0;
        main_data_q <= '0;
        skid_ctrl_q <= '0;
        skid_data_q <= '0;
      end else begin
        if (load_main) begin
          main_ctrl_q <= i_ctrl;
          main_data_q <= i_data;
        end else if (skid_to_main) begin
          main_ctrl_q <= skid_ctrl_q;
          main_data_q <= skid_data_q;
        end
        if (load_skid) begin
          skid_ctrl_q <= i_ctrl;
          skid_data_q <= i_data;
        end
      end
    end
  end

  assign stall_inc = o_valid & ~out_acc & ~i_flush;
  assign flush_inc = i_flush ? ({1'b0, o_valid} + {1'b0, (state_q == ST_SKID)}) : 2'd0;

  sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (stall_inc),
    .o_count (o_stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(2)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (flush_inc),
    .o_count (o_flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - scoreboard bench for the elastic pipeline stage
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        valid = 1'b0, stall = 1'b0, flush = 1'b0, ready_dn = 1'b0;
  logic [7:0]  ctrl = '0;
  logic [35:0] data = '0;
  logic        m_ready, m_valid_o;
  logic [7:0]  m_ctrl_o;
  logic [35:0] m_data_o;
  logic [15:0] m_stall_cnt, m_flush_cnt;
  logic        s_ready, s_valid_o;
  logic [7:0]  s_ctrl_o;
  logic [35:0] s_data_o;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  logic        n_valid = 1'b0, n_ready_dn = 1'b0;
  logic        n_stall = 1'b0, n_flush = 1'b0;
  logic [7:0]  n_ctrl = '0;
  logic [35:0] n_data = '0;
  logic        n_ready, n_valid_o;
  logic [7:0]  n_ctrl_o;
  logic [35:0] n_data_o;
  logic [15:0] n_stall_cnt, n_flush_cnt;

  int errors = 0;
  int checks = 0;
  int pops = 0;
  logic [43:0] sb[$];

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_WIDTH(36), .CTRL_WIDTH(8), .SKID_EN(1), .CNT_WIDTH(16)) u_main (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(m_ready), .i_ctrl(ctrl), .i_data(data),
    .i_stall(stall), .i_flush(flush), .o_valid(m_valid_o), .i_ready(ready_dn), .o_ctrl(m_ctrl_o),
    .o_data(m_data_o), .o_stall_cnt(m_stall_cnt), .o_flush_cnt(m_flush_cnt)
  );

  pipe_stage_elastic #(.DATA_WIDTH(36), .CTRL_WIDTH(8), .SKID_EN(1), .CNT_WIDTH(4)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(s_ready), .i_ctrl(ctrl), .i_data(data),
    .i_stall(stall), .i_flush(flush), .o_valid(s_valid_o), .i_ready(ready_dn), .o_ctrl(s_ctrl_o),
    .o_data(s_data_o), .o_stall_cnt(s_stall_cnt), .o_flush_cnt(s_flush_cnt)
  );

  pipe_stage_elastic #(.DATA_WIDTH(36), .CTRL_WIDTH(8), .SKID_EN(0), .CNT_WIDTH(16)) u_ns (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(n_valid), .o_ready(n_ready), .i_ctrl(n_ctrl), .i_data(n_data),
    .i_stall(n_stall), .i_flush(n_flush), .o_valid(n_valid_o), .i_ready(n_ready_dn), .o_ctrl(n_ctrl_o),
    .o_data(n_data_o), .o_stall_cnt(n_stall_cnt), .o_flush_cnt(n_flush_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [35:0] d,
                       input logic r, input logic s, input logic f);
    @(posedge clk);
    #1;
    valid = v; ctrl = c; data = d; ready_dn = r; stall = s; flush = f;
  endtask

  task automatic ndrive(input logic v, input logic [7:0] c, input logic [35:0] d, input logic r);
    @(posedge clk);
    #1;
    n_valid = v; n_ctrl = c; n_data = d; n_ready_dn = r;
  endtask

  // Monitor: retire on output transfer, drop everything on flush, enqueue on accepted input.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (m_valid_o && ready_dn && !stall && !flush) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_output", {m_ctrl_o, m_data_o}, 44'h0);
        end else begin
          check("sb_entry", {20'h0, m_ctrl_o, m_data_o}, {20'h0, sb.pop_front()});
          pops++;
        end
      end
      if (flush) sb.delete();
      if (valid && m_ready && !flush) sb.push_back({ctrl, data});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #22;
    check("rst_valid", m_valid_o, 0);
    check("rst_ctrl", m_ctrl_o, 0);
    check("rst_data", m_data_o, 0);
    check("rst_ready", m_ready, 1);
    check("rst_stall_cnt", m_stall_cnt, 0);
    check("rst_flush_cnt", m_flush_cnt, 0);
    check("rst_ns_ready", n_ready, 1);
    rst_n = 1'b1;

    // Back-to-back stream 1..8
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 8'(k), 36'(k), 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("t1_ready", m_ready, 1);
      if (k > 1) check("t1_data_lag", {m_valid_o, m_data_o}, {1'b1, 36'(k - 1)});
    end
    drive(1'b0, 8'h0, 36'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_last", {m_valid_o, m_data_o}, {1'b1, 36'd8});
    drive(1'b0, 8'h0, 36'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_drained", m_valid_o, 0);
    check("t1_stall_cnt", m_stall_cnt, 0);

    // Backpressure into the skid
    drive(1'b1, 8'h11, 36'h0A0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 36'h0B0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_ready_b", m_ready, 1);
    drive(1'b0, 8'h0, 36'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_ready_skid_full", m_ready, 0);
    check("t2_main_a", m_data_o, 36'h0A0);
    drive(1'b0, 8'h0, 36'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h0, 36'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_stall_cnt", m_stall_cnt, 3);
    check("t2_ready_still_low", m_ready, 0);
    drive(1'b0, 8'h0, 36'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_main_b", {m_valid_o, m_data_o}, {1'b1, 36'h0B0});
    check("t2_ready_back", m_ready, 1);
    drive(1'b0, 8'h0, 36'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_empty", m_valid_o, 0);
    check("t2_stall_final", m_stall_cnt, 3);

    // Flush with main and skid both valid
    drive(1'b1, 8'hA5, 36'h123456789, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hA5, 36'h0000ABCDE, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h77, 36'h000000EEE, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h0, 36'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t3_valid", m_valid_o, 0);
    check("t3_ctrl", m_ctrl_o, 0);
    check("t3_data", m_data_o, 0);
    check("t3_ready", m_ready, 1);
    check("t3_flush_cnt", m_flush_cnt, 2);
    check("t3_stall_cnt", m_stall_cnt, 4);
    drive(1'b1, 8'h33, 36'h033, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 8'h0, 36'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t3_flush_drop_input", m_valid_o, 0);
    check("t3_flush_cnt_empty", m_flush_cnt, 2);

    // Stall overrides ready
    drive(1'b1, 8'h44, 36'h444, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 8'h0, 36'h0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check("t4_hold", {m_valid_o, m_ctrl_o, m_data_o}, {1'b1, 8'h44, 36'h444});
    end
    drive(1'b0, 8'h0, 36'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_stall_cnt", m_stall_cnt, 7);

    // Long block: 16-bit counter keeps counting, 4-bit counter pins at 15
    drive(1'b1, 8'h55, 36'h555, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) drive(1'b0, 8'h0, 36'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h0, 36'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_stall_cnt", m_stall_cnt, 27);
    check("t5_sat_cnt", s_stall_cnt, 15);

    // Flush with only main valid
    drive(1'b1, 8'h66, 36'h666, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h0, 36'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h0, 36'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_flush_one", m_flush_cnt, 3);
    check("t5_stall_after_flush", m_stall_cnt, 27);
    check("t5_sat_flush", s_flush_cnt, 3);
    check("sb_pops", pops, 12);
    check("sb_leftover", sb.size(), 0);

    // Single-entry mode: combinational ready and concurrent in/out
    ndrive(1'b1, 8'h01, 36'h100, 1'b0);
    @(negedge clk);
    check("ns_ready_empty", n_ready, 1);
    ndrive(1'b1, 8'h02, 36'h200, 1'b0);
    @(negedge clk);
    check("ns_ready_blocked", {n_valid_o, n_ready}, 2'b10);
    check("ns_data_x", n_data_o, 36'h100);
    ndrive(1'b1, 8'h02, 36'h200, 1'b1);
    @(negedge clk);
    check("ns_ready_pass", n_ready, 1);
    ndrive(1'b0, 8'h0, 36'h0, 1'b0);
    @(negedge clk);
    check("ns_data_y", {n_valid_o, n_ctrl_o, n_data_o}, {1'b1, 8'h02, 36'h200});
    check("ns_stall_cnt", n_stall_cnt, 1);

    // Asynchronous reset mid-cycle
    drive(1'b1, 8'h99, 36'h999, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    check("ar_loaded", m_valid_o, 1);
    rst_n = 1'b0;
    #1;
    check("ar_valid", m_valid_o, 0);
    check("ar_data", {m_ctrl_o, m_data_o}, 44'h0);
    check("ar_counters", {m_stall_cnt, m_flush_cnt}, 32'h0);
    check("ar_ready", m_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
